cordic_seq_ctrl: RTL and testbench

- Sequencer for the 16-bit pipelined hyperbolic CORDIC core.
- On a start request it:
  - pulses the core reset;
  - streams a 64-entry x 48-bit coefficient LUT from an external synchronous-read memory into the core's write port;
  - releases the core into run mode with latched fcw/offset;
  - collects a programmed number of amplitude samples and signals done.
- Sits between the system control plane and the CORDIC core; owns every core control pin.

---
 rtl/cordic_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_cordic_seq_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the pipelined hyperbolic CORDIC core: it resets the core, streams the
// coefficient LUT in from an external synchronous-read memory, runs the core and collects samples.
module cordic_seq_ctrl #(
    parameter int LUT_DEPTH = 64,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 48,
    parameter int PH_W      = 16,
    parameter int CNT_W     = 16,
    parameter int RST_CYC   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [PH_W-1:0]   fcw_in,
    input  logic [PH_W-1:0]   offset_in,
    input  logic [CNT_W-1:0]  n_samples,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic              cdc_reset,
    output logic              cdc_cen,
    output logic              cdc_wen,
    output logic [ADDR_W-1:0] cdc_index,
    output logic [DATA_W-1:0] cdc_d,
    output logic [PH_W-1:0]   cdc_fcw,
    output logic [PH_W-1:0]   cdc_offset,
    input  logic [PH_W-1:0]   cdc_amp,
    input  logic              cdc_valid,
    output logic [PH_W-1:0]   sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done
);

    // Control handshake: start and abort are single-cycle pulses with no ready; start is
    // accepted only while busy is low and abort is low, abort wins over start and completion,
    // and cdc_valid qualifies cdc_amp on the cycle it is high, with no backpressure.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RST  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int RC_W = (RST_CYC < 2) ? 1 : $clog2(RST_CYC + 1);
    localparam int LC_W = ADDR_W + 1;

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [RC_W-1:0]   rst_cnt;
    logic [LC_W-1:0]   load_cnt;
    logic [CNT_W-1:0]  smp_cnt;
    logic [CNT_W-1:0]  smp_next;
    logic [CNT_W-1:0]  n_lat;
    logic              last_sample;

    assign smp_next    = smp_cnt + CNT_W'(1);
    assign last_sample = cdc_valid && (n_lat != '0) && (smp_next == n_lat);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start && !abort) state_next = S_RST;
            S_RST: begin
                if (abort)                                state_next = S_IDLE;
                else if (rst_cnt == RC_W'(RST_CYC - 1))   state_next = S_LOAD;
            end
            S_LOAD: begin
                if (abort)                                state_next = S_IDLE;
                else if (load_cnt == LC_W'(LUT_DEPTH))    state_next = S_RUN;
            end
            S_RUN: begin
                if (abort)                                state_next = S_IDLE;
                else if (last_sample)                     state_next = S_DONE;
            end
            S_DONE:                                       state_next = S_IDLE;
            default:                                      state_next = S_IDLE;
        endcase
    end

    // Core control pins are pure decodes of the state register.
    assign cdc_reset = (state == S_IDLE) || (state == S_RST) || (state == S_DONE);
    assign cdc_cen   = (state == S_IDLE) || (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign cdc_d     = src_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            rst_cnt      <= '0;
            load_cnt     <= '0;
            smp_cnt      <= '0;
            n_lat        <= '0;
            src_addr     <= '0;
            cdc_wen      <= 1'b1;
            cdc_index    <= '0;
            cdc_fcw      <= '0;
            cdc_offset   <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_next;
            sample_valid <= 1'b0;
            cdc_wen      <= 1'b1;
            case (state)
                S_IDLE: begin
                    rst_cnt   <= '0;
                    load_cnt  <= '0;
                    smp_cnt   <= '0;
                    src_addr  <= '0;
                    cdc_index <= '0;
                    if (state_next == S_RST) begin
                        cdc_fcw    <= fcw_in;
                        cdc_offset <= offset_in;
                        n_lat      <= n_samples;
                    end
                end
                S_RST: begin
                    rst_cnt <= rst_cnt + RC_W'(1);
                end
                S_LOAD: begin
                    // The write strobe trails the read address by one cycle to match the
                    // memory's read latency, so index k is written while address k+1 is read.
                    if (state_next == S_LOAD) begin
                        cdc_wen   <= 1'b0;
                        cdc_index <= load_cnt[ADDR_W-1:0];
                        load_cnt  <= load_cnt + LC_W'(1);
                        if (src_addr != ADDR_W'(LUT_DEPTH - 1))
                            src_addr <= src_addr + ADDR_W'(1);
                    end
                end
                S_RUN: begin
                    if (!abort && cdc_valid) begin
                        sample_out   <= cdc_amp;
                        sample_valid <= 1'b1;
                        smp_cnt      <= smp_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Randomized bench for cordic_seq_ctrl: a memory model, a core-output driver and a
// monitor that predicts the write sequence and captured samples from the sequencing rules.
module tb_cordic_seq_ctrl;

    localparam int LUT_DEPTH = 64;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 48;
    localparam int PH_W      = 16;
    localparam int CNT_W     = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [PH_W-1:0]   fcw_in = '0;
    logic [PH_W-1:0]   offset_in = '0;
    logic [CNT_W-1:0]  n_samples = '0;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_data = '0;
    logic              cdc_reset;
    logic              cdc_cen;
    logic              cdc_wen;
    logic [ADDR_W-1:0] cdc_index;
    logic [DATA_W-1:0] cdc_d;
    logic [PH_W-1:0]   cdc_fcw;
    logic [PH_W-1:0]   cdc_offset;
    logic [PH_W-1:0]   cdc_amp = '0;
    logic              cdc_valid = 1'b0;
    logic [PH_W-1:0]   sample_out;
    logic              sample_valid;
    logic              busy;
    logic              done;

    cordic_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .fcw_in(fcw_in), .offset_in(offset_in), .n_samples(n_samples),
        .src_addr(src_addr), .src_data(src_data),
        .cdc_reset(cdc_reset), .cdc_cen(cdc_cen), .cdc_wen(cdc_wen),
        .cdc_index(cdc_index), .cdc_d(cdc_d), .cdc_fcw(cdc_fcw), .cdc_offset(cdc_offset),
        .cdc_amp(cdc_amp), .cdc_valid(cdc_valid),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy), .done(done)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    int checks = 0;
    int failures = 0;
    logic [DATA_W-1:0] lut [LUT_DEPTH];
    logic [ADDR_W-1:0] wr_q [$];
    logic [PH_W-1:0]   exp_q [$];
    logic [PH_W-1:0]   got_q [$];
    int cap_cyc [$];
    int got_cyc [$];
    int cyc = 0;
    int wr_bad = 0;
    int ctrl_bad = 0;
    int fcw_bad = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int remaining = 0;
    int vmode = 0;
    int ph = 0;
    bit run_ph = 1'b0;
    logic [PH_W-1:0]  exp_fcw = '0;
    logic [PH_W-1:0]  exp_off = '0;
    logic [CNT_W-1:0] n_lat = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Synchronous-read LUT memory: data for the address seen in one cycle appears in the next.
    initial begin
        logic [ADDR_W-1:0] a;
        forever begin
            @(negedge clk);
            a = src_addr;
            @(posedge clk);
            #1 src_data = lut[a];
        end
    end

    // Core output driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ph++;
            if (vmode == 1) cdc_valid = (ph % 3 == 0);
            else            cdc_valid = 1'($urandom_range(0, 1));
            cdc_amp = PH_W'($urandom);
        end
    end

    // Monitor and reference model, sampled just before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (cdc_wen === 1'b0) begin
                wr_q.push_back(cdc_index);
                if (cdc_d !== lut[cdc_index]) wr_bad++;
                if (cdc_reset !== 1'b0 || cdc_cen !== 1'b0) ctrl_bad++;
            end
            if (sample_valid === 1'b1) begin
                got_q.push_back(sample_out);
                got_cyc.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy === 1'b1 && (cdc_fcw !== exp_fcw || cdc_offset !== exp_off)) fcw_bad++;
            if (run_ph) begin
                if (cdc_wen !== 1'b1 || cdc_cen !== 1'b0 || cdc_reset !== 1'b0) ctrl_bad++;
                if (abort === 1'b1) begin
                    run_ph = 1'b0;
                end else if (cdc_valid === 1'b1) begin
                    exp_q.push_back(cdc_amp);
                    cap_cyc.push_back(cyc);
                    if (n_lat != 0) begin
                        remaining--;
                        if (remaining == 0) run_ph = 1'b0;
                    end
                end
            end
            if (cdc_wen === 1'b0 && cdc_index === ADDR_W'(LUT_DEPTH - 1)) run_ph = 1'b1;
        end
    end

    // Driver / checking tasks
    task automatic clear_logs();
        wr_q.delete(); exp_q.delete(); got_q.delete(); cap_cyc.delete(); got_cyc.delete();
        wr_bad = 0; ctrl_bad = 0; fcw_bad = 0; done_cnt = 0; done_cyc = -1;
        run_ph = 1'b0;
    endtask

    task automatic do_start(input logic [PH_W-1:0] f, input logic [PH_W-1:0] o,
                            input logic [CNT_W-1:0] n);
        clear_logs();
        exp_fcw = f; exp_off = o; n_lat = n; remaining = int'(n);
        @(posedge clk);
        #1;
        fcw_in = f; offset_in = o; n_samples = n; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        fcw_in = PH_W'($urandom); offset_in = PH_W'($urandom); n_samples = CNT_W'($urandom);
    endtask

    task automatic check_rst_len(input string p);
        int n = 0;
        @(negedge clk);
        while (cdc_reset === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({p, "_rst_len"}, n, 4);
    endtask

    task automatic wait_done(input string p, input int max_cyc);
        int n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check({p, "_done_seen"}, done, 1);
        check({p, "_busy_at_done"}, busy, 1);
        @(negedge clk);
        check({p, "_busy_after_done"}, busy, 0);
        check({p, "_done_width"}, done, 0);
    endtask

    task automatic check_load(input string p);
        int errs = 0;
        check({p, "_wr_count"}, wr_q.size(), LUT_DEPTH);
        for (int i = 0; i < wr_q.size(); i++)
            if (int'(wr_q[i]) != i) errs++;
        check({p, "_wr_order"}, errs, 0);
        check({p, "_wr_data"}, wr_bad, 0);
        check({p, "_ctrl_pins"}, ctrl_bad, 0);
        check({p, "_fcw_off"}, fcw_bad, 0);
    endtask

    task automatic check_samples(input string p);
        int errs = 0;
        check({p, "_smp_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i] || got_cyc[i] != cap_cyc[i] + 1) errs++;
        check({p, "_smp_data"}, errs, 0);
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_cdc_reset"}, cdc_reset, 1);
        check({p, "_cdc_cen"}, cdc_cen, 1);
        check({p, "_cdc_wen"}, cdc_wen, 1);
        check({p, "_cdc_index"}, cdc_index, 0);
        check({p, "_src_addr"}, src_addr, 0);
        check({p, "_cdc_fcw"}, cdc_fcw, 0);
        check({p, "_cdc_offset"}, cdc_offset, 0);
        check({p, "_sample_out"}, sample_out, 0);
        check({p, "_sample_valid"}, sample_valid, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, done, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < LUT_DEPTH; i++) lut[i] = {16'(i), 32'($urandom())};

        #2 reset = 1'b1;
        #20 check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic load and run of 8 samples
        vmode = 0;
        do_start(16'h0111, 16'h0000, 16'd8);
        check_rst_len("s1");
        wait_done("s1", 3000);
        check_load("s1");
        check_samples("s1");
        check("s1_nsmp", got_q.size(), 8);
        check("s1_done_cnt", done_cnt, 1);
        check("s1_done_timing", done_cyc, (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size() - 1] + 1 : -1);

        // Free-run, abort after 100 captures
        do_start(16'h1234, 16'h0042, 16'd0);
        check_rst_len("s2");
        n = 0;
        while (exp_q.size() < 100 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("s2_busy", busy, 0);
        check("s2_cdc_reset", cdc_reset, 1);
        check("s2_sample_valid", sample_valid, 0);
        check("s2_cdc_wen", cdc_wen, 1);
        repeat (3) @(negedge clk);
        check("s2_nsmp", got_q.size(), 100);
        check_samples("s2");
        check_load("s2");
        check("s2_no_done", done_cnt, 0);

        // Start during LOAD ignored; fcw_in change during RUN ignored
        do_start(16'h0111, 16'h0005, 16'd8);
        check_rst_len("s3");
        repeat (10) @(negedge clk);
        start = 1'b1;
        fcw_in = 16'h0333;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!run_ph && n < 200) begin
            @(negedge clk);
            n++;
        end
        fcw_in = 16'h0222;
        wait_done("s3", 3000);
        check_load("s3");
        check_samples("s3");
        check("s3_done_cnt", done_cnt, 1);
        check("s3_fcw_kept", cdc_fcw, 16'h0111);

        // Asynchronous reset in the middle of the load
        do_start(16'h0abc, 16'h0101, 16'd4);
        check_rst_len("s4a");
        n = 0;
        while (!(cdc_wen === 1'b0 && cdc_index === 6'd30) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("s4_reached_idx30", cdc_index, 30);
        #2 reset = 1'b1;
        #1 check_reset_vals("s4");
        @(negedge clk);
        reset = 1'b0;
        do_start(16'h0abc, 16'h0101, 16'd4);
        check_rst_len("s4b");
        wait_done("s4", 3000);
        check_load("s4");
        check_samples("s4");

        // Single sample with sparse valids
        vmode = 1;
        do_start(16'h0777, 16'h0000, 16'd1);
        check_rst_len("s5");
        wait_done("s5", 3000);
        check("s5_nsmp", got_q.size(), 1);
        check_samples("s5");
        check("s5_done_timing", done_cyc, (cap_cyc.size() > 0) ? cap_cyc[0] + 1 : -1);
        check("s5_done_cnt", done_cnt, 1);
        vmode = 0;

        // start+abort together in IDLE, then abort coincident with the final sample
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        fcw_in = 16'h0999;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0 || cdc_reset !== 1'b1) n++;
            @(negedge clk);
        end
        check("s6_start_abort_idle", n, 0);

        do_start(16'h0111, 16'h0000, 16'd8);
        check_rst_len("s6");
        n = 0;
        while (!(run_ph && remaining == 1 && cdc_valid === 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("s6_busy", busy, 0);
        check("s6_sample_valid", sample_valid, 0);
        repeat (3) @(negedge clk);
        check("s6_no_done", done_cnt, 0);
        check("s6_nsmp", got_q.size(), 7);
        check_samples("s6");
        check_load("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
